// File: rtl/sync_to_count_lock.sv
// sync_to_count_lock
//   Delays HSync/VSync by one clock and derives column/row counters from them.
//   A VSync start edge zeroes both counters. With H_RESYNC set, an HSync start
//   edge realigns the column counter. Frame/line start strobes are produced,
//   and a lock tracker reports when the incoming timing has matched the
//   expected geometry for LOCK_FRAMES consecutive frames.
//
// Ports
//   i_Clk          pixel clock, rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_HSync        horizontal sync, synchronous to i_Clk
//   i_VSync        vertical sync, synchronous to i_Clk
//   o_HSync        i_HSync delayed one clock
//   o_VSync        i_VSync delayed one clock
//   o_Col_Count    column counter, 0..TOTAL_COLS-1
//   o_Row_Count    row counter, 0..TOTAL_ROWS-1
//   o_Frame_Start  one-clock strobe: counters were just zeroed by a VSync edge
//   o_Line_Start   one-clock strobe: o_Col_Count just became 0
//   o_Locked       timing has matched the geometry for LOCK_FRAMES frames
//   o_Err          one-clock strobe on a timing violation while not unlocked
module sync_to_count_lock #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int CNT_WIDTH   = 10,
    parameter int SYNC_POL    = 1,
    parameter int H_RESYNC    = 1,
    parameter int LOCK_FRAMES = 3
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_HSync,
    input  logic                 i_VSync,
    output logic                 o_HSync,
    output logic                 o_VSync,
    output logic [CNT_WIDTH-1:0] o_Col_Count,
    output logic [CNT_WIDTH-1:0] o_Row_Count,
    output logic                 o_Frame_Start,
    output logic                 o_Line_Start,
    output logic                 o_Locked,
    output logic                 o_Err
);

    localparam logic                 ACT      = (SYNC_POL != 0);
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(TOTAL_ROWS - 1);
    localparam int                   GW       = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES);
    localparam logic [GW-1:0]        GOOD_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        CHECK,
        LOCKED
    } state_t;

    state_t               state;
    logic [GW-1:0]        good_cnt;

    logic                 v_edge;
    logic                 h_edge;
    logic                 h_rs;
    logic                 at_line_end;
    logic                 at_frame_end;
    logic                 good_v;
    logic                 bad_evt;
    logic [CNT_WIDTH-1:0] row_inc;
    logic [CNT_WIDTH-1:0] col_nxt;
    logic [CNT_WIDTH-1:0] row_nxt;

    // Start edges: input at the active level while its delayed copy is not.
    assign v_edge = (i_VSync == ACT) && (o_VSync != ACT);
    assign h_edge = (i_HSync == ACT) && (o_HSync != ACT);
    assign h_rs   = (H_RESYNC != 0) && h_edge;

    assign at_line_end  = (o_Col_Count == COL_LAST);
    assign at_frame_end = at_line_end && (o_Row_Count == ROW_LAST);
    assign row_inc      = (o_Row_Count == ROW_LAST) ? '0 : o_Row_Count + 1'b1;

    always_comb begin
        col_nxt = o_Col_Count + 1'b1;
        row_nxt = o_Row_Count;
        if (v_edge) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (h_rs || at_line_end) begin
            col_nxt = '0;
            row_nxt = row_inc;
        end
    end

    // A VSync edge is good only when it lands on the natural wrap point.
    // Reaching the wrap point without one is a missed frame; an HSync resync
    // landing on the last column has the same effect as the natural wrap, so
    // it is treated the same way. A resync edge anywhere else is a line error.
    // A VSync edge masks a simultaneous HSync edge.
    assign good_v  = v_edge && at_frame_end;
    assign bad_evt = v_edge ? !at_frame_end
                            : (at_frame_end || (h_rs && !at_line_end));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_HSync       <= ~ACT;
            o_VSync       <= ~ACT;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Frame_Start <= 1'b0;
            o_Line_Start  <= 1'b0;
        end else begin
            o_HSync       <= i_HSync;
            o_VSync       <= i_VSync;
            o_Col_Count   <= col_nxt;
            o_Row_Count   <= row_nxt;
            o_Frame_Start <= v_edge;
            o_Line_Start  <= (col_nxt == '0);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            o_Locked <= 1'b0;
            o_Err    <= 1'b0;
        end else begin
            o_Err <= 1'b0;
            case (state)
                UNLOCKED: begin
                    // The first VSync edge only establishes a reference frame.
                    if (v_edge) begin
                        state    <= CHECK;
                        good_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (bad_evt) begin
                        good_cnt <= '0;
                        o_Err    <= 1'b1;
                    end else if (good_v) begin
                        if (good_cnt == GOOD_LAST) begin
                            state    <= LOCKED;
                            good_cnt <= '0;
                            o_Locked <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (bad_evt) begin
                        state    <= CHECK;
                        good_cnt <= '0;
                        o_Err    <= 1'b1;
                        o_Locked <= 1'b0;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    good_cnt <= '0;
                    o_Locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_to_count_lock.sv
module tb_sync_to_count_lock;

    localparam int TC    = 8;
    localparam int TR    = 4;
    localparam int CW    = 3;
    localparam int LOCK  = 2;
    localparam int FRAME = TC * TR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v_act = 1'b0;
    logic h_act = 1'b0;

    // Active-high instance
    logic p_hs, p_vs, p_fs, p_ls, p_lk, p_err;
    logic [CW-1:0] p_col, p_row;
    // Active-low instance, fed the inverted syncs
    logic n_hs, n_vs, n_fs, n_ls, n_lk, n_err;
    logic [CW-1:0] n_col, n_row;

    always #5 clk = ~clk;

    sync_to_count_lock #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .CNT_WIDTH(CW),
                         .SYNC_POL(1), .H_RESYNC(1), .LOCK_FRAMES(LOCK)) dut_p (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(h_act), .i_VSync(v_act),
        .o_HSync(p_hs), .o_VSync(p_vs), .o_Col_Count(p_col), .o_Row_Count(p_row),
        .o_Frame_Start(p_fs), .o_Line_Start(p_ls), .o_Locked(p_lk), .o_Err(p_err));

    sync_to_count_lock #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .CNT_WIDTH(CW),
                         .SYNC_POL(0), .H_RESYNC(1), .LOCK_FRAMES(LOCK)) dut_n (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(~h_act), .i_VSync(~v_act),
        .o_HSync(n_hs), .o_VSync(n_vs), .o_Col_Count(n_col), .o_Row_Count(n_row),
        .o_Frame_Start(n_fs), .o_Line_Start(n_ls), .o_Locked(n_lk), .o_Err(n_err));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: linear position within the frame plus lock bookkeeping.
    int m_pos;
    bit m_pv, m_ph, m_fs, m_ls, m_err;
    int m_state;   // 0 unlocked, 1 checking, 2 locked
    int m_good;

    task automatic model_reset();
        m_pos = 0; m_pv = 0; m_ph = 0;
        m_fs = 0; m_ls = 0; m_err = 0;
        m_state = 0; m_good = 0;
    endtask

    task automatic model_step(input bit v, input bit h);
        bit ve, he, at_end, bad;
        int col, row;
        ve = v && !m_pv;
        he = h && !m_ph;
        col = m_pos % TC;
        row = m_pos / TC;
        at_end = (m_pos == FRAME - 1);
        bad = ve ? !at_end : (at_end || (he && col != TC - 1));
        m_err = 0;
        if (m_state == 0) begin
            if (ve) begin m_state = 1; m_good = 0; end
        end else if (bad) begin
            m_state = 1; m_good = 0; m_err = 1;
        end else if (ve && m_state == 1) begin
            m_good++;
            if (m_good == LOCK) m_state = 2;
        end
        m_fs = ve;
        if (ve) m_pos = 0;
        else if (he) m_pos = ((row + 1) % TR) * TC;
        else m_pos = (m_pos + 1) % FRAME;
        m_ls = (m_pos % TC == 0);
        m_pv = v;
        m_ph = h;
    endtask

    function automatic logic [11:0] exp_vec();
        return {m_ph, m_pv, 3'(m_pos % TC), 3'(m_pos / TC),
                m_fs, m_ls, (m_state == 2), m_err};
    endfunction

    function automatic logic [11:0] obs_p();
        return {p_hs, p_vs, p_col, p_row, p_fs, p_ls, p_lk, p_err};
    endfunction

    function automatic logic [11:0] obs_n();
        return {~n_hs, ~n_vs, n_col, n_row, n_fs, n_ls, n_lk, n_err};
    endfunction

    function automatic bit aligned_v();
        return (m_pos == FRAME - 1) || (m_pos == 0);
    endfunction

    function automatic bit aligned_h();
        return (m_pos % TC == TC - 1) || (m_pos % TC == 0);
    endfunction

    // Drive one clock of sync levels; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit v, input bit h);
        v_act = v;
        h_act = h;
        @(posedge clk);
        model_step(v, h);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; v_act = 0; h_act = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk += 2;
        if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL reset_pos got=%h exp=%h", obs_p(), exp_vec()); end
        if (obs_n() !== exp_vec()) begin n_fail++; $display("FAIL reset_neg got=%h exp=%h", obs_n(), exp_vec()); end
        n_chk++;
        if (n_vs !== 1'b1) begin n_fail++; $display("FAIL reset_neg_vsync_level got=%b exp=1", n_vs); end
        rst_n = 1;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            step(0, 0);
            n_chk += 2;
            if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL free_run_pos cyc=%0d got=%h exp=%h", cyc, obs_p(), exp_vec()); end
            if (obs_n() !== exp_vec()) begin n_fail++; $display("FAIL free_run_neg cyc=%0d got=%h exp=%h", cyc, obs_n(), exp_vec()); end
        end
    endtask

    task automatic test_lock_acquire();
        int edges = 0;
        int lock_edge = 0;
        for (int i = 0; i < 5 * FRAME && m_state != 2; i++) begin
            step(aligned_v(), aligned_h());
            if (m_fs) edges++;
            lock_edge = edges;
            n_chk += 2;
            if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL lock_acq_pos cyc=%0d got=%h exp=%h", cyc, obs_p(), exp_vec()); end
            if (obs_n() !== exp_vec()) begin n_fail++; $display("FAIL lock_acq_neg cyc=%0d got=%h exp=%h", cyc, obs_n(), exp_vec()); end
        end
        n_chk += 2;
        if (p_lk !== 1'b1 || n_lk !== 1'b1) begin n_fail++; $display("FAIL lock_acq_locked got=%b/%b exp=1", p_lk, n_lk); end
        if (lock_edge != LOCK + 1) begin n_fail++; $display("FAIL lock_acq_edges got=%0d exp=%0d", lock_edge, LOCK + 1); end
    endtask

    task automatic test_early_vsync();
        for (int i = 0; i < 2 * FRAME && m_pos != FRAME - 6; i++) step(aligned_v(), aligned_h());
        step(1, aligned_h());
        n_chk += 3;
        if (p_col !== 0 || p_row !== 0 || n_col !== 0 || n_row !== 0) begin
            n_fail++; $display("FAIL early_v_zero got=%0d,%0d exp=0,0", p_col, p_row);
        end
        if (p_err !== 1'b1 || n_err !== 1'b1) begin n_fail++; $display("FAIL early_v_err got=%b/%b exp=1", p_err, n_err); end
        if (p_lk !== 1'b0 || n_lk !== 1'b0) begin n_fail++; $display("FAIL early_v_unlock got=%b/%b exp=0", p_lk, n_lk); end
        for (int i = 0; i < 5 * FRAME && m_state != 2; i++) begin
            step(aligned_v(), aligned_h());
            n_chk += 2;
            if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL early_v_relock_pos cyc=%0d got=%h exp=%h", cyc, obs_p(), exp_vec()); end
            if (obs_n() !== exp_vec()) begin n_fail++; $display("FAIL early_v_relock_neg cyc=%0d got=%h exp=%h", cyc, obs_n(), exp_vec()); end
        end
        n_chk++;
        if (p_lk !== 1'b1 || n_lk !== 1'b1) begin n_fail++; $display("FAIL early_v_relocked got=%b/%b exp=1", p_lk, n_lk); end
    endtask

    task automatic test_missing_vsync();
        for (int i = 0; i < 2 * FRAME && m_pos != FRAME - 1; i++) step(aligned_v(), aligned_h());
        step(0, aligned_h());
        n_chk += 3;
        if (p_err !== 1'b1 || n_err !== 1'b1) begin n_fail++; $display("FAIL miss_v_err got=%b/%b exp=1", p_err, n_err); end
        if (p_fs !== 1'b0 || n_fs !== 1'b0) begin n_fail++; $display("FAIL miss_v_no_fs got=%b/%b exp=0", p_fs, n_fs); end
        if (p_lk !== 1'b0 || n_lk !== 1'b0) begin n_fail++; $display("FAIL miss_v_unlock got=%b/%b exp=0", p_lk, n_lk); end
        step(0, aligned_h());
        for (int i = 0; i < FRAME - 3; i++) begin
            step(aligned_v(), aligned_h());
            n_chk += 2;
            if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL miss_v_frame_pos cyc=%0d got=%h exp=%h", cyc, obs_p(), exp_vec()); end
            if (p_fs !== 1'b0) begin n_fail++; $display("FAIL miss_v_fs cyc=%0d got=%b exp=0", cyc, p_fs); end
        end
    endtask

    task automatic test_hsync_midline();
        bit tracking;
        for (int i = 0; i < 2 * FRAME && m_pos != TC + 3; i++) step(aligned_v(), aligned_h());
        tracking = (m_state != 0);
        step(aligned_v(), 1);
        n_chk += 4;
        if (p_col !== 0 || n_col !== 0) begin n_fail++; $display("FAIL hsync_mid_col got=%0d exp=0", p_col); end
        if (p_row !== 2 || n_row !== 2) begin n_fail++; $display("FAIL hsync_mid_row got=%0d exp=2", p_row); end
        if (p_ls !== 1'b1 || n_ls !== 1'b1) begin n_fail++; $display("FAIL hsync_mid_ls got=%b exp=1", p_ls); end
        if (p_err !== tracking || n_err !== tracking) begin n_fail++; $display("FAIL hsync_mid_err got=%b exp=%b", p_err, tracking); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6 * FRAME && m_state != 2; i++) step(aligned_v(), aligned_h());
        for (int i = 0; i < 2 * FRAME && m_pos != 2 * TC + 5; i++) step(aligned_v(), aligned_h());
        n_chk++;
        if (p_lk !== 1'b1 || p_col !== 5 || p_row !== 2) begin
            n_fail++; $display("FAIL async_rst_pre got=%b,%0d,%0d exp=1,5,2", p_lk, p_col, p_row);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        n_chk += 2;
        if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL async_rst_pos got=%h exp=%h", obs_p(), exp_vec()); end
        if (obs_n() !== exp_vec()) begin n_fail++; $display("FAIL async_rst_neg got=%h exp=%h", obs_n(), exp_vec()); end
        v_act = 0; h_act = 0;
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_random();
        bit v, h;
        int r;
        for (int i = 0; i < 800; i++) begin
            v = aligned_v();
            h = aligned_h();
            r = int'($urandom_range(0, 99));
            if (r < 2) v = 1;
            else if (r < 4) h = 1;
            else if (r < 6) v = 0;
            else if (r < 7) h = 0;
            step(v, h);
            n_chk += 2;
            if (obs_p() !== exp_vec()) begin n_fail++; $display("FAIL random_pos cyc=%0d got=%h exp=%h", cyc, obs_p(), exp_vec()); end
            if (obs_n() !== exp_vec()) begin n_fail++; $display("FAIL random_neg cyc=%0d got=%h exp=%h", cyc, obs_n(), exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_lock_acquire();
        test_early_vsync();
        test_missing_vsync();
        test_hsync_midline();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
